// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared tap table, FSM encoding and default-seed helper for lfsr_bank
package lfsr_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Maximal-length taps; bit (t-1) is set for every tap t of the polynomial.
    function automatic logic [15:0] tap_mask(int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            16:      return 16'hD008;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] galois_mask(int w);
        logic [15:0] m;
        logic [15:0] r;
        m = tap_mask(w);
        r = '0;
        for (int i = 0; i < w; i++) r[w-1-i] = m[i];
        return r;
    endfunction

    function automatic logic [15:0] default_seed(int w, logic [7:0] base, logic [7:0] step, int k);
        int s;
        s = (int'(base) + k * int'(step)) % (1 << w);
        if (s == 0) s = 1;
        return 16'(s);
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - one LFSR channel: state register with reseed, load and step
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter int               GALOIS = 0,
    parameter logic [WIDTH-1:0] SEED   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reseed,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             step,
    output logic [WIDTH-1:0] value
);

    localparam logic [WIDTH-1:0] FIB_MASK = WIDTH'(tap_mask(WIDTH));
    localparam logic [WIDTH-1:0] GAL_MASK = WIDTH'(galois_mask(WIDTH));

    logic [WIDTH-1:0] nxt;

    always_comb begin
        nxt = '0;
        if (GALOIS != 0)
            nxt = {value[WIDTH-2:0], 1'b0} ^ (value[WIDTH-1] ? GAL_MASK : '0);
        else
            nxt = {value[WIDTH-2:0], ^(value & FIB_MASK)};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        value <= SEED;
        else if (reseed) value <= SEED;
        else if (load)   value <= load_data;
        else if (step)   value <= nxt;
    end

endmodule

// File: rtl/lfsr_bank.sv
// rtl/lfsr_bank.sv - multi-channel LFSR generator with burst FSM and valid/ready output
module lfsr_bank
    import lfsr_pkg::*;
#(
    parameter int         WIDTH     = 8,
    parameter int         NUM_CH    = 4,
    parameter int         GALOIS    = 0,
    parameter logic [7:0] SEED_BASE = 8'hA5,
    parameter logic [7:0] SEED_STEP = 8'h1D,
    parameter int         COUNT_W   = 16,
    localparam int        CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rst_lfsr,
    input  logic                    en_lfsr,
    input  logic                    start,
    input  logic [COUNT_W-1:0]      num_samples,
    input  logic                    seed_we,
    input  logic [CH_W-1:0]         seed_ch,
    input  logic [WIDTH-1:0]        seed_data,
    output logic [NUM_CH*WIDTH-1:0] out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    lockup_err
);

    localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

    state_t             state;
    logic [COUNT_W-1:0] cnt;
    logic [COUNT_W-1:0] num_q;
    logic               consume;
    logic               start_ok;
    logic               seed_ok;
    logic [WIDTH-1:0]   seed_val;

    assign out_valid = (state == S_RUN) && en_lfsr;
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign consume   = out_valid && out_ready && !rst_lfsr;
    assign start_ok  = (state == S_IDLE) && start && (num_samples != '0) && !rst_lfsr;
    assign seed_ok   = seed_we && (state != S_RUN) && !rst_lfsr && (32'(seed_ch) < NUM_CH);
    // A zero seed would lock the register at zero forever, so it is replaced by 1.
    assign seed_val  = (seed_data == '0) ? WIDTH'(1) : seed_data;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        lfsr_core #(
            .WIDTH  (WIDTH),
            .GALOIS (GALOIS),
            .SEED   (WIDTH'(default_seed(WIDTH, SEED_BASE, SEED_STEP, k)))
        ) u_core (
            .clk       (clk),
            .rst       (rst),
            .reseed    (rst_lfsr),
            .load      (seed_ok && (32'(seed_ch) == k)),
            .load_data (seed_val),
            .step      (consume),
            .value     (out[k*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            num_q      <= '0;
            lockup_err <= 1'b0;
        end else if (rst_lfsr) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lockup_err <= 1'b0;
        end else begin
            if (seed_ok && (seed_data == '0)) lockup_err <= 1'b1;
            case (state)
                S_IDLE: if (start_ok) begin
                    state <= S_RUN;
                    cnt   <= '0;
                    num_q <= num_samples;
                end
                S_RUN: if (consume) begin
                    cnt <= cnt + ONE;
                    if (cnt == num_q - ONE) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_bank.sv
// tb/tb_lfsr_bank.sv - randomized self-checking bench for lfsr_bank against a behavioural model
module tb_lfsr_bank;

    logic        clk = 1'b0;
    logic        rst, rst_lfsr, en_lfsr, start, seed_we, out_ready;
    logic [15:0] num_samples;
    logic [1:0]  seed_ch;
    logic [7:0]  seed_data;
    logic [23:0] out;
    logic        out_valid, busy, done, lockup_err;

    logic        g_start, g_valid, g_busy, g_done, g_lock;
    logic [15:0] g_num, g_out;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mdl [3];
    logic [7:0] seen0 [$];

    bit g_seen [65536];
    int g_cnt = 0, g_dup = 0, g_zero = 0;
    bit g_done_seen = 0;

    always #5 clk = ~clk;

    lfsr_bank #(.WIDTH(8), .NUM_CH(3), .GALOIS(0)) u_dut (
        .clk(clk), .rst(rst), .rst_lfsr(rst_lfsr), .en_lfsr(en_lfsr), .start(start),
        .num_samples(num_samples), .seed_we(seed_we), .seed_ch(seed_ch), .seed_data(seed_data),
        .out(out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
        .lockup_err(lockup_err)
    );

    lfsr_bank #(.WIDTH(16), .NUM_CH(1), .GALOIS(1)) u_gal (
        .clk(clk), .rst(rst), .rst_lfsr(1'b0), .en_lfsr(1'b1), .start(g_start),
        .num_samples(g_num), .seed_we(1'b0), .seed_ch(1'b0), .seed_data(16'h0000),
        .out(g_out), .out_valid(g_valid), .out_ready(1'b1), .busy(g_busy), .done(g_done),
        .lockup_err(g_lock)
    );

    always @(negedge clk) begin
        if (rst && g_valid) begin
            if (g_seen[g_out]) g_dup++;
            if (g_out == 16'h0000) g_zero++;
            g_seen[g_out] = 1'b1;
            g_cnt++;
        end
        if (g_done) g_done_seen = 1'b1;
    end

    function automatic logic [7:0] fib8(input logic [7:0] v);
        int x;
        x = int'(v);
        return 8'(((x << 1) | (((x >> 7) ^ (x >> 5) ^ (x >> 4) ^ (x >> 3)) & 1)) & 255);
    endfunction

    function automatic logic [7:0] dflt(input int k);
        int s;
        s = (165 + k * 29) % 256;
        return (s == 0) ? 8'h01 : 8'(s);
    endfunction

    function automatic logic [23:0] exp_out();
        return {mdl[2], mdl[1], mdl[0]};
    endfunction

    task automatic reset_model();
        for (int k = 0; k < 3; k++) mdl[k] = dflt(k);
    endtask

    task automatic advance_model();
        for (int k = 0; k < 3; k++) mdl[k] = fib8(mdl[k]);
    endtask

    task automatic write_seed(input int ch, input logic [7:0] data);
        seed_we = 1'b1; seed_ch = 2'(ch); seed_data = data;
        @(negedge clk);
        seed_we = 1'b0;
        if (ch < 3) mdl[ch] = (data == 8'h00) ? 8'h01 : data;
    endtask

    task automatic burst_check(input int n, input int rdy_pct, input int en_pct, output int cyc);
        int left;
        bit fin;
        start = 1'b1; num_samples = 16'(n); out_ready = 1'b0; en_lfsr = 1'b1;
        @(negedge clk);
        start = 1'b0; seed_we = 1'b0;
        left = n; fin = 1'b0; cyc = 0;
        while (!fin && cyc < 20 * n + 50) begin
            out_ready = ($urandom_range(99) < rdy_pct);
            en_lfsr   = ($urandom_range(99) < en_pct);
            cyc++;
            #1;
            n_tests++;
            if (left > 0) begin
                if (busy !== 1'b1 || done !== 1'b0 || out_valid !== en_lfsr || out !== exp_out()) begin
                    n_fail++;
                    $display("FAIL burst_run cyc=%0d: busy=%b done=%b valid=%b out=%h, want busy=1 done=0 valid=%b out=%h",
                             cyc, busy, done, out_valid, out, en_lfsr, exp_out());
                end
                if (en_lfsr && out_ready) begin
                    seen0.push_back(out[7:0]);
                    advance_model();
                    left--;
                end
            end else begin
                if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL burst_done: done=%b busy=%b valid=%b, want 1 0 0", done, busy, out_valid);
                end
                fin = 1'b1;
            end
            @(negedge clk);
        end
        out_ready = 1'b0; en_lfsr = 1'b1;
        n_tests++;
        if (!fin) begin
            n_fail++;
            $display("FAIL burst_timeout: done not seen after %0d cycles, want done after %0d samples", cyc, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rst_lfsr = 1'b0; en_lfsr = 1'b1; start = 1'b0; seed_we = 1'b0;
        out_ready = 1'b0; num_samples = '0; seed_ch = '0; seed_data = '0;
        g_start = 1'b0; g_num = '0;
        repeat (2) @(negedge clk);
        reset_model();
        #1;
        n_tests++;
        if (out !== 24'hDFC2A5 || out_valid !== 0 || busy !== 0 || done !== 0 || lockup_err !== 0) begin
            n_fail++;
            $display("FAIL reset_hold: out=%h v=%b b=%b d=%b l=%b, want out=dfc2a5 all flags 0",
                     out, out_valid, busy, done, lockup_err);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (out !== exp_out() || busy !== 0 || out_valid !== 0) begin
            n_fail++;
            $display("FAIL reset_release: out=%h busy=%b valid=%b, want %h 0 0", out, busy, out_valid, exp_out());
        end
    endtask

    task automatic test_sequence();
        logic [7:0] want [5];
        int c;
        want = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
        write_seed(0, 8'h01);
        seen0.delete();
        burst_check(5, 100, 100, c);
        n_tests++;
        if (c !== 6) begin
            n_fail++;
            $display("FAIL seq_done_cycle: done at cycle %0d, want 6", c);
        end
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (i >= seen0.size() || seen0[i] !== want[i]) begin
                n_fail++;
                $display("FAIL seq_value[%0d]: got %h want %h", i, (i < seen0.size()) ? seen0[i] : 8'hxx, want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        start = 1'b1; num_samples = 16'd6; out_ready = 1'b1; en_lfsr = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            out_ready = !(i >= 2 && i < 5);
            #1;
            n_tests++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || out !== exp_out()) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: valid=%b busy=%b out=%h, want 1 1 %h", i, out_valid, busy, out, exp_out());
            end
            if (out_ready) advance_model();
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_done: done=%b want 1", done);
        end
        @(negedge clk);
    endtask

    task automatic test_pause_reseed();
        start = 1'b1; num_samples = 16'd20; out_ready = 1'b1; en_lfsr = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            advance_model();
        end
        en_lfsr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (out_valid !== 1'b0 || busy !== 1'b1 || out !== exp_out()) begin
                n_fail++;
                $display("FAIL pause[%0d]: valid=%b busy=%b out=%h, want 0 1 %h", i, out_valid, busy, out, exp_out());
            end
            @(negedge clk);
        end
        en_lfsr = 1'b1;
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out !== exp_out()) begin
            n_fail++;
            $display("FAIL pause_resume: valid=%b out=%h, want 1 %h", out_valid, out, exp_out());
        end
        rst_lfsr = 1'b1;
        @(negedge clk);
        rst_lfsr = 1'b0;
        reset_model();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (done !== 1'b0 || busy !== 1'b0 || out !== exp_out()) begin
                n_fail++;
                $display("FAIL reseed[%0d]: done=%b busy=%b out=%h, want 0 0 %h", i, done, busy, out, exp_out());
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_period();
        bit hit [256];
        int c, zeros, dups;
        write_seed(0, 8'h01);
        seen0.delete();
        burst_check(255, 100, 100, c);
        zeros = 0; dups = 0;
        foreach (seen0[i]) begin
            if (seen0[i] == 8'h00) zeros++;
            if (hit[seen0[i]]) dups++;
            hit[seen0[i]] = 1'b1;
        end
        #1;
        n_tests++;
        if (out[7:0] !== 8'h01) begin
            n_fail++;
            $display("FAIL period_return: ch0=%h want 01", out[7:0]);
        end
        n_tests++;
        if (zeros != 0 || dups != 0) begin
            n_fail++;
            $display("FAIL period_values: zeros=%0d repeats=%0d, want 0 0", zeros, dups);
        end
    endtask

    task automatic test_edge();
        int c;
        write_seed(3, 8'h00);
        #1;
        n_tests++;
        if (lockup_err !== 1'b0 || out !== exp_out()) begin
            n_fail++;
            $display("FAIL seed_ch_range: lock=%b out=%h, want 0 %h", lockup_err, out, exp_out());
        end
        write_seed(1, 8'h00);
        #1;
        n_tests++;
        if (out[15:8] !== 8'h01 || lockup_err !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_seed: ch1=%h lock=%b, want 01 1", out[15:8], lockup_err);
        end
        start = 1'b1; num_samples = 16'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_zero: busy=%b valid=%b, want 0 0", busy, out_valid);
        end
        start = 1'b1; num_samples = 16'd4; out_ready = 1'b0; en_lfsr = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seed_we = 1'b1; seed_ch = 2'd0; seed_data = 8'h55;
        @(negedge clk);
        seed_we = 1'b0;
        #1;
        n_tests++;
        if (out !== exp_out() || busy !== 1'b1 || lockup_err !== 1'b1) begin
            n_fail++;
            $display("FAIL seed_in_run: out=%h busy=%b lock=%b, want %h 1 1", out, busy, lockup_err, exp_out());
        end
        rst_lfsr = 1'b1;
        @(negedge clk);
        rst_lfsr = 1'b0;
        reset_model();
        #1;
        n_tests++;
        if (lockup_err !== 1'b0 || busy !== 1'b0 || out !== exp_out()) begin
            n_fail++;
            $display("FAIL lock_clear: lock=%b busy=%b out=%h, want 0 0 %h", lockup_err, busy, out, exp_out());
        end
        seed_we = 1'b1; seed_ch = 2'd2; seed_data = 8'h3C;
        mdl[2] = 8'h3C;
        burst_check(3, 100, 100, c);
    endtask

    task automatic test_random();
        int c;
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 3; k++) write_seed(k, 8'($urandom_range(1, 255)));
            burst_check($urandom_range(1, 12), 70, 75, c);
        end
    endtask

    task automatic test_galois();
        int guard;
        guard = 0;
        while (!g_done_seen && guard < 70000) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (!g_done_seen) begin
            n_fail++;
            $display("FAIL galois_timeout: done not seen, want done after 65535 samples");
        end
        n_tests++;
        if (g_out !== 16'h00A5 || g_cnt != 65535 || g_dup != 0 || g_zero != 0) begin
            n_fail++;
            $display("FAIL galois_period: out=%h samples=%0d repeats=%0d zeros=%0d, want 00a5 65535 0 0",
                     g_out, g_cnt, g_dup, g_zero);
        end
    endtask

    initial begin
        test_reset();
        g_start = 1'b1; g_num = 16'hFFFF;
        @(negedge clk);
        g_start = 1'b0;
        test_sequence();
        test_backpressure();
        test_pause_reseed();
        test_period();
        test_edge();
        test_random();
        test_galois();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
